ysyx_23060332_lsu: RTL

//  Load/store unit directly downstream of the execute stage. Takes one decoded memory op per

---
 rtl/ysyx_23060332_lsu.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: accepts one execute-stage record, issues at most one aligned
// memory request, and produces the write-back record for the WBU.
module ysyx_23060332_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_func3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_waddr,
  input  logic        in_reg_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_waddr,
  output logic [31:0] out_wdata,
  output logic        out_reg_wen,
  output logic        out_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned XLEN  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        off_q, off_d;
  logic              ld_wen_q, ld_wen_d;
  logic              in_ready_q, in_ready_d;
  logic              req_valid_q, req_valid_d;
  logic              req_we_q, req_we_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_waddr_q, out_waddr_d;
  logic [XLEN-1:0]   out_wdata_q, out_wdata_d;
  logic              out_reg_wen_q, out_reg_wen_d;
  logic              out_err_q, out_err_d;

  logic              op_err;
  logic [XLEN-1:0]   st_wdata;
  logic [3:0]        st_wstrb;
  logic [XLEN-1:0]   ld_word;
  logic [XLEN-1:0]   ld_data;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout;

  // Reject ren&wen, illegal widths and misaligned accesses before touching the bus
  always_comb begin
    op_err = 1'b0;
    if (in_ren && in_wen) begin
      op_err = 1'b1;
    end else if (in_ren) begin
      case (in_func3)
        3'b000, 3'b100: op_err = 1'b0;
        3'b001, 3'b101: op_err = in_addr[0];
        3'b010:         op_err = (in_addr[1:0] != 2'b00);
        default:        op_err = 1'b1;
      endcase
    end else if (in_wen) begin
      case (in_func3)
        3'b000:  op_err = 1'b0;
        3'b001:  op_err = in_addr[0];
        3'b010:  op_err = (in_addr[1:0] != 2'b00);
        default: op_err = 1'b1;
      endcase
    end
  end

  // Store lane replication and byte strobes
  always_comb begin
    st_wdata = in_wdata;
    st_wstrb = 4'b1111;
    case (in_func3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << in_addr[1:0];
        st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << in_addr[1:0];
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    ld_word = mem_rsp_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_data = {24'd0, ld_word[7:0]};
      3'b101:  ld_data = {16'd0, ld_word[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(MAX_WAIT));

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    func3_d       = func3_q;
    off_d         = off_q;
    ld_wen_d      = ld_wen_q;
    in_ready_d    = in_ready_q;
    req_valid_d   = req_valid_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    out_valid_d   = out_valid_q;
    out_waddr_d   = out_waddr_q;
    out_wdata_d   = out_wdata_q;
    out_reg_wen_d = out_reg_wen_q;
    out_err_d     = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d    = 1'b0;
          func3_d       = in_func3;
          off_d         = in_addr[1:0];
          out_waddr_d   = in_waddr;
          out_err_d     = 1'b0;
          out_wdata_d   = '0;
          out_reg_wen_d = 1'b0;
          if (!in_ren && !in_wen) begin
            state_d       = S_DONE;
            out_valid_d   = 1'b1;
            out_wdata_d   = in_alu_result;
            out_reg_wen_d = in_reg_wen & (in_waddr != 5'd0);
          end else if (op_err) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            ld_wen_d    = in_ren & in_reg_wen & (in_waddr != 5'd0);
            req_valid_d = 1'b1;
            req_we_d    = in_wen;
            req_addr_d  = {in_addr[31:2], 2'b00};
            req_wdata_d = in_wen ? st_wdata : '0;
            req_wstrb_d = in_wen ? st_wstrb : 4'b0000;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d     = S_DONE;
          req_valid_d = 1'b0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
        end else if (mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
        end else if (mem_rsp_valid) begin
          state_d       = S_DONE;
          out_valid_d   = 1'b1;
          out_wdata_d   = req_we_q ? '0 : ld_data;
          out_reg_wen_d = ld_wen_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        req_valid_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      func3_q       <= '0;
      off_q         <= '0;
      ld_wen_q      <= 1'b0;
      in_ready_q    <= 1'b1;
      req_valid_q   <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
      out_valid_q   <= 1'b0;
      out_waddr_q   <= '0;
      out_wdata_q   <= '0;
      out_reg_wen_q <= 1'b0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      func3_q       <= func3_d;
      off_q         <= off_d;
      ld_wen_q      <= ld_wen_d;
      in_ready_q    <= in_ready_d;
      req_valid_q   <= req_valid_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_wstrb_q   <= req_wstrb_d;
      out_valid_q   <= out_valid_d;
      out_waddr_q   <= out_waddr_d;
      out_wdata_q   <= out_wdata_d;
      out_reg_wen_q <= out_reg_wen_d;
      out_err_q     <= out_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_valid     = out_valid_q;
  assign out_waddr     = out_waddr_q;
  assign out_wdata     = out_wdata_q;
  assign out_reg_wen   = out_reg_wen_q;
  assign out_err       = out_err_q;

endmodule
